acumulador_ctrl: RTL and testbench
==================================

ACUMULADOR_CTRL -- requirements
Module: acumulador_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter CNT_W, default 4, word-count width (max run 2^CNT_W-1 words).
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request a run; sampled only in IDLE.
REQ-006 BaseAddr  input  ADDR_W  address of first operand word; captured on accepted Start.
REQ-007 Count  input  CNT_W  number of words to accumulate; captured on accepted Start.
REQ-008 MemAddr  output  ADDR_W  operand address to memory.
REQ-009 MemRead  output  1  memory read strobe; read data is valid on DataIN the following cycle.
REQ-010 Clear  output  1  one-cycle pulse that zeroes the accumulator register.
REQ-011 Load  output  1  one-cycle pulse that captures DataIN into the operand register.
REQ-012 Transfer  output  1  one-cycle pulse that writes operand + accumulator into the accumulator register.
REQ-013 Busy  output  1  high from the cycle after Start acceptance until Done.
REQ-014 Done  output  1  one-cycle pulse marking run completion; the accumulator output is final.

Function
REQ-015 The FSM SHALL have the states IDLE, CLR, FETCH, LOAD, ADD and FIN.
REQ-016 In IDLE, Start=1 SHALL capture BaseAddr/Count, clear the word index i to 0 and go to CLR.
REQ-017 CLR SHALL assert Clear for exactly one cycle; the next state is FIN if the captured Count==0, else FETCH.
REQ-018 FETCH SHALL assert MemRead with MemAddr=captured BaseAddr+i (modulo 2^ADDR_W, wraps silently); next state LOAD.
REQ-019 LOAD SHALL assert Load for one cycle; next state ADD.
REQ-020 ADD SHALL assert Transfer for one cycle and increment i; the next state is FIN if i+1==Count, else FETCH.
REQ-021 FIN SHALL assert Done for one cycle and return to IDLE; Busy SHALL be low in FIN.
REQ-022 Latency: the Done pulse SHALL occur 3*Count+2 cycles after the Start-accept edge (Count=0 -> 2 cycles).
REQ-023 Clear, Load, Transfer, MemRead and Done SHALL be registered, mutually exclusive, and never high for two consecutive cycles.
REQ-024 Start while Busy, or in FIN, SHALL be ignored; BaseAddr/Count changes during a run SHALL have no effect.
REQ-025 Start held high continuously SHALL begin a new run on the IDLE cycle following each FIN.
REQ-026 MemAddr SHALL hold its last value outside FETCH; MemRead SHALL be 0 outside FETCH.
REQ-027 Datapath sum overflow is not detected; the accumulator wraps modulo 2^16.

Reset
REQ-028 Reset=1 at a rising edge SHALL force IDLE, i=0, MemAddr=0, and Clear=Load=Transfer=MemRead=Busy=Done=0, overriding Start.
REQ-029 Reset asserted mid-run SHALL abort the run with no further strobes; the accumulator contents are undefined until the next CLR.

Structure
REQ-030 The state encoding and the ADDR_W/CNT_W defaults SHALL reside in the shared package acumulador_pkg.
REQ-031 The word index with its terminal-count compare SHALL be a sub-module, contador_palavras (synchronous clear, enable, CNT_W wide, output last = (q+1==limit)).
REQ-032 The controller SHALL connect its Load/Clear/Transfer outputs directly to the existing accumulator datapath with no glue logic.

Verification
REQ-033 Reset, then Start with BaseAddr=0x10 and Count=3, memory[0x10..0x12]=5,7,9 -> one Clear, MemAddr 0x10,0x11,0x12, three Load/Transfer pairs, Done at cycle 11, DataOut=21.
REQ-034 Count=0 and Start -> Clear, then Done 2 cycles after accept; no MemRead/Load/Transfer pulses; DataOut=0.
REQ-035 BaseAddr=0xFE and Count=4 -> MemAddr sequence 0xFE,0xFF,0x00,0x01.
REQ-036 Second Start pulse and BaseAddr change issued mid-run -> ignored; the first run completes unchanged, and only one Done pulse occurs.
REQ-037 Reset asserted during the second LOAD of a Count=5 run -> the next cycle is IDLE with all outputs 0; a new Start with Count=2 and data 1,2 -> DataOut=3.
REQ-038 Start held high, Count=1 and memory value 0xFFFF -> back-to-back runs separated by one IDLE cycle; each Done is followed by DataOut=0xFFFF, and every run begins with a Clear.

Source files
------------

// File: rtl/acumulador_pkg.sv
// Shared definitions for the accumulator run controller: default widths,
// datapath width and the controller state encoding.
package acumulador_pkg;

    localparam int ADDR_W_DEF = 8;   // memory address width
    localparam int CNT_W_DEF  = 4;   // word-count width (max run 2^CNT_W-1)
    localparam int DATA_W     = 16;  // accumulator / operand width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ADD   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // A run is in progress (Busy) in every state between acceptance and FIN.
    function automatic logic is_active(input state_e s);
        return (s == ST_CLR) || (s == ST_FETCH) || (s == ST_LOAD) || (s == ST_ADD);
    endfunction

endpackage

// File: rtl/contador_palavras.sv
// Word index counter: synchronous clear, count enable, and a terminal-count
// flag that is high when the next increment would reach the limit.
module contador_palavras #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] q_o,
    output logic             last_o
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Next index: clear wins over enable.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign last_o = ((q_q + CNT_W'(1)) == limit_i);

endmodule

// File: rtl/acumulador_ctrl.sv
// Accumulator run controller. On an accepted start it clears the
// accumulator, then for each word fetches it from memory, loads it into
// the operand register and transfers operand+accumulator back into the
// accumulator, finishing with a one-cycle done pulse.
//
// Handshake: start_i is a level request sampled only in IDLE (there is no
// ready); base_addr_i/count_i are captured on the accepting edge. busy_o is
// high while the run is active and done_o pulses once when data_out_o is
// final. Memory answers a mem_read_o cycle with data_in_i one cycle later.
module acumulador_ctrl
    import acumulador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              clear_o,
    output logic              load_o,
    output logic              transfer_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_out_o,
    output state_e            state_o
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic mem_read_q, mem_read_d;
    logic clear_q, clear_d;
    logic load_q, load_d;
    logic transfer_q, transfer_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic             idx_clr;
    logic             idx_en;
    logic [CNT_W-1:0] idx;
    logic             idx_last;
    logic [CNT_W-1:0] idx_fetch;

    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    contador_palavras #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (idx_clr),
        .en_i    (idx_en),
        .limit_i (count_q),
        .q_o     (idx),
        .last_o  (idx_last)
    );

    // Next state, operand capture and index control.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_clr = 1'b0;
        idx_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    count_d = count_i;
                    idx_clr = 1'b1;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = (count_q == '0) ? ST_FIN : ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_ADD;
            end
            ST_ADD: begin
                idx_en  = 1'b1;
                state_d = idx_last ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, so each one
    // is high exactly during the cycle its state is occupied.
    always_comb begin
        mem_read_d = (state_d == ST_FETCH);
        clear_d    = (state_d == ST_CLR);
        load_d     = (state_d == ST_LOAD);
        transfer_d = (state_d == ST_ADD);
        done_d     = (state_d == ST_FIN);
        busy_d     = is_active(state_d);
        // Leaving ADD the index has not yet incremented, so the fetch
        // address uses the post-increment value.
        idx_fetch  = (state_q == ST_ADD) ? (idx + CNT_W'(1)) : idx;
        mem_addr_d = mem_addr_q;
        if (state_d == ST_FETCH) begin
            mem_addr_d = base_q + ADDR_W'(idx_fetch);
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            transfer_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
            clear_q    <= clear_d;
            load_q     <= load_d;
            transfer_q <= transfer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Accumulator datapath driven straight from the controller strobes;
    // the sum wraps modulo 2^DATA_W.
    always_comb begin
        op_d  = op_q;
        acc_d = acc_q;
        if (load_q) begin
            op_d = data_in_i;
        end
        if (clear_q) begin
            acc_d = '0;
        end else if (transfer_q) begin
            acc_d = acc_q + op_q;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q  <= '0;
            acc_q <= '0;
        end else begin
            op_q  <= op_d;
            acc_q <= acc_d;
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_read_o = mem_read_q;
    assign clear_o    = clear_q;
    assign load_o     = load_q;
    assign transfer_o = transfer_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign data_out_o = acc_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_acumulador_ctrl.sv
// Bench for acumulador_ctrl: directed runs against a small memory model,
// expected addresses and results queued by the driver and checked by a
// free-running monitor.
module tb_acumulador_ctrl;
    import acumulador_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [3:0]  count;
    logic [15:0] data_in;
    logic [7:0]  mem_addr_o;
    logic        mem_read_o;
    logic        clear_o;
    logic        load_o;
    logic        transfer_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] data_out_o;
    state_e      state_o;

    acumulador_ctrl #(
        .ADDR_W (8),
        .CNT_W  (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .count_i     (count),
        .data_in_i   (data_in),
        .mem_addr_o  (mem_addr_o),
        .mem_read_o  (mem_read_o),
        .clear_o     (clear_o),
        .load_o      (load_o),
        .transfer_o  (transfer_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .data_out_o  (data_out_o),
        .state_o     (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (mem_read_o) data_in <= mem[mem_addr_o];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    int          exp_cnt_q[$];
    logic [7:0]  exp_addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [4:0]  strb;
    logic [4:0]  prev_strb = '0;
    logic        prev_busy = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [7:0]  prev_addr = '0;
    int          run_start = 0;
    int          last_done = -1;
    int          run_clears = 0;
    int          run_loads = 0;
    int          run_xfers = 0;
    logic        held_mode = 1'b0;
    logic [15:0] e_data;
    int          e_cnt;
    logic [7:0]  e_addr;

    always @(negedge clk) begin
        strb = {clear_o, load_o, transfer_o, mem_read_o, done_o};
        if (rst) begin
            run_clears = 0;
            run_loads  = 0;
            run_xfers  = 0;
            prev_strb  = '0;
            prev_busy  = 1'b0;
            prev_rst   = 1'b1;
            prev_addr  = mem_addr_o;
        end else begin
            chk("strobe_onehot", 32'($countones(strb) <= 1), 32'(1));
            chk("strobe_repeat", 32'(strb & prev_strb), 32'(0));
            if (done_o) chk("busy_in_fin", 32'(busy_o), 32'(0));
            if (busy_o && !prev_busy) begin
                run_start = cyc;
                if (held_mode && last_done >= 0) chk("held_gap", 32'(cyc - last_done), 32'(2));
            end
            if (clear_o)    run_clears++;
            if (load_o)     run_loads++;
            if (transfer_o) run_xfers++;
            if (mem_read_o) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_memread actual=%0h required=none", mem_addr_o);
                end else begin
                    e_addr = exp_addr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
                end
            end else if (!prev_rst) begin
                chk("mem_addr_hold", 32'(mem_addr_o), 32'(prev_addr));
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=none", data_out_o);
                end else begin
                    e_data = exp_q.pop_front();
                    e_cnt  = exp_cnt_q.pop_front();
                    chk("data_out", 32'(data_out_o), 32'(e_data));
                    chk("latency", 32'(cyc - run_start + 1), 32'(3 * e_cnt + 2));
                    chk("clear_pulses", 32'(run_clears), 32'(1));
                    chk("load_pulses", 32'(run_loads), 32'(e_cnt));
                    chk("transfer_pulses", 32'(run_xfers), 32'(e_cnt));
                end
                run_clears = 0;
                run_loads  = 0;
                run_xfers  = 0;
                last_done  = cyc;
            end
            prev_strb = strb;
            prev_busy = busy_o;
            prev_rst  = 1'b0;
            prev_addr = mem_addr_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"},    32'(state_o), 32'(ST_IDLE));
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'(0));
        chk({tag, "_outputs"},
            32'({clear_o, load_o, transfer_o, mem_read_o, busy_o, done_o}), 32'(0));
    endtask

    task automatic issue_start(input logic [7:0] b, input logic [3:0] c);
        @(negedge clk);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_run(input logic [7:0] b, input int c, input logic [15:0] d);
        for (int i = 0; i < c; i++) exp_addr_q.push_back(8'(b + i));
        exp_q.push_back(d);
        exp_cnt_q.push_back(c);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_o), 32'(1));
    endtask

    task automatic run_case(input logic [7:0] b, input logic [3:0] c, input logic [15:0] d);
        expect_run(b, int'(c), d);
        issue_start(b, c);
        wait_done();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        data_in   = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'd5;    mem[8'h11] = 16'd7;    mem[8'h12] = 16'd9;
        mem[8'hFE] = 16'h1000; mem[8'hFF] = 16'h0200;
        mem[8'h00] = 16'h0030; mem[8'h01] = 16'h0004;
        mem[8'h20] = 16'd100;  mem[8'h21] = 16'd200;
        for (int i = 8'h30; i < 8'h38; i++) mem[i] = 16'h7777;
        for (int i = 8'h40; i < 8'h45; i++) mem[i] = 16'h0101;
        mem[8'h50] = 16'd1;    mem[8'h51] = 16'd2;
        mem[8'h60] = 16'hFFFF;
        for (int i = 8'h70; i < 8'h7F; i++) mem[i] = 16'h1111;

        // Reset state, with start requested during reset.
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic three-word run.
        run_case(8'h10, 4'd3, 16'd21);
        // Empty run.
        run_case(8'h10, 4'd0, 16'd0);
        // Address wrap.
        run_case(8'hFE, 4'd4, 16'h1234);
        // Maximum count; sum lands on 0xFFFF.
        run_case(8'h70, 4'd15, 16'hFFFF);

        // Start and new operands while busy are ignored.
        expect_run(8'h20, 2, 16'd300);
        issue_start(8'h20, 4'd2);
        repeat (3) @(negedge clk);
        base_addr = 8'h30;
        count     = 4'd7;
        start     = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);

        // Reset during the second LOAD of a five-word run.
        exp_addr_q.push_back(8'h40);
        exp_addr_q.push_back(8'h41);
        issue_start(8'h40, 4'd5);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (3) @(negedge clk);
        run_case(8'h50, 4'd2, 16'd3);

        // Start held high: three back-to-back single-word runs.
        last_done = -1;
        held_mode = 1'b1;
        for (int k = 0; k < 3; k++) expect_run(8'h60, 1, 16'hFFFF);
        @(negedge clk);
        base_addr = 8'h60;
        count     = 4'd1;
        start     = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        held_mode = 1'b0;

        chk("pending_results", 32'(exp_q.size()), 32'(0));
        chk("pending_addresses", 32'(exp_addr_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
